// File: rtl/timer_alarm_pkg.sv
// Shared types for the timer alarm stage: FSM state encoding.
package timer_alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_WATCH    = 2'd1,
        ST_RELOAD   = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/timer_alarm.sv
// Event stage behind the timer core: sticky match/expiry flags, maskable irq,
// saturating expiry count and optional periodic re-start of the core.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_DISARMED | idle; timer activity ignored until arm
// ST_WATCH    | watching for compare match and falling edge of running
// ST_RELOAD   | start re-issued after expiry; waiting for running to return
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          curr_timer,
    input  logic                 running,
    input  logic                 stop,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [31:0]          compare_value,
    input  logic                 compare_en,
    input  logic                 match_irq_en,
    input  logic                 expire_irq_en,
    input  logic                 auto_restart,
    input  logic [CNT_WIDTH-1:0] restart_limit,
    input  logic                 irq_ack,
    output logic                 timer_start,
    output logic                 match_status,
    output logic                 expire_status,
    output logic [CNT_WIDTH-1:0] expire_count,
    output logic                 irq
);

    alarm_state_t         state, state_nxt;
    logic                 running_d;
    logic                 match_fired, match_fired_nxt;
    logic                 start_nxt;
    logic                 match_set;
    logic                 expire_set;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic [CNT_WIDTH:0]   count_plus;
    logic                 expiry;
    logic                 match_hit;
    logic                 restart_ok;

    // One bit wider than the counter so the limit compare never wraps.
    assign count_plus = {1'b0, expire_count} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign restart_ok = auto_restart &&
                        ((restart_limit == '0) || (count_plus < {1'b0, restart_limit}));
    assign expiry     = running_d && !running;
    assign match_hit  = compare_en && running && (curr_timer == compare_value) && !match_fired;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_DISARMED;
            running_d     <= 1'b0;
            match_fired   <= 1'b0;
            timer_start   <= 1'b0;
            match_status  <= 1'b0;
            expire_status <= 1'b0;
            expire_count  <= '0;
        end else begin
            state         <= state_nxt;
            running_d     <= running;
            match_fired   <= match_fired_nxt;
            timer_start   <= start_nxt;
            match_status  <= match_set  || (match_status  && !irq_ack);
            expire_status <= expire_set || (expire_status && !irq_ack);
            expire_count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        match_fired_nxt = match_fired;
        start_nxt       = 1'b0;
        match_set       = 1'b0;
        expire_set      = 1'b0;
        count_nxt       = expire_count;

        if (disarm || stop) begin
            state_nxt = ST_DISARMED;
        end else begin
            case (state)
                ST_DISARMED: begin
                    if (arm) begin
                        state_nxt       = ST_WATCH;
                        count_nxt       = '0;
                        match_fired_nxt = 1'b0;
                    end
                end
                ST_WATCH: begin
                    if (match_hit) begin
                        match_set       = 1'b1;
                        match_fired_nxt = 1'b1;
                    end
                    if (expiry) begin
                        expire_set = 1'b1;
                        if (!(&expire_count)) begin
                            count_nxt = count_plus[CNT_WIDTH-1:0];
                        end
                        if (restart_ok) begin
                            start_nxt = 1'b1;
                            state_nxt = ST_RELOAD;
                        end else begin
                            state_nxt = ST_DISARMED;
                        end
                    end
                end
                ST_RELOAD: begin
                    // Single start pulse already issued; a core that never restarts leaves us here until disarm/stop.
                    if (running) begin
                        state_nxt       = ST_WATCH;
                        match_fired_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = ST_DISARMED;
                end
            endcase
        end
    end

    assign irq = (match_status && match_irq_en) || (expire_status && expire_irq_en);

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm with a small down-counting timer core model;
// a second CNT_WIDTH=2 instance shares the stimulus to exercise saturation.
module tb_timer_alarm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] curr_timer;
    logic        running;
    logic        stop, arm, disarm, compare_en, match_irq_en, expire_irq_en;
    logic        auto_restart, irq_ack, sw_start;
    logic [31:0] compare_value, timer_init;
    logic [15:0] restart_limit;

    logic        timer_start, match_status, expire_status, irq;
    logic [15:0] expire_count;
    logic        timer_start2, match_status2, expire_status2, irq2;
    logic [1:0]  expire_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_alarm #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .curr_timer(curr_timer), .running(running),
        .stop(stop), .arm(arm), .disarm(disarm), .compare_value(compare_value),
        .compare_en(compare_en), .match_irq_en(match_irq_en), .expire_irq_en(expire_irq_en),
        .auto_restart(auto_restart), .restart_limit(restart_limit), .irq_ack(irq_ack),
        .timer_start(timer_start), .match_status(match_status), .expire_status(expire_status),
        .expire_count(expire_count), .irq(irq)
    );

    timer_alarm #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .curr_timer(curr_timer), .running(running),
        .stop(stop), .arm(arm), .disarm(disarm), .compare_value(compare_value),
        .compare_en(compare_en), .match_irq_en(match_irq_en), .expire_irq_en(expire_irq_en),
        .auto_restart(auto_restart), .restart_limit(2'b00), .irq_ack(irq_ack),
        .timer_start(timer_start2), .match_status(match_status2), .expire_status(expire_status2),
        .expire_count(expire_count2), .irq(irq2)
    );

    // Timer core model: start sampled only when idle, counts down to 0, then drops running.
    always @(posedge clk) begin
        if (!reset_n) begin
            running    <= 1'b0;
            curr_timer <= 32'd0;
        end else if (stop) begin
            running <= 1'b0;
        end else if (!running && (timer_start || sw_start)) begin
            running    <= 1'b1;
            curr_timer <= timer_init;
        end else if (running) begin
            if (curr_timer == 32'd0) running <= 1'b0;
            else curr_timer <= curr_timer - 32'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm_start();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        sw_start = 1'b1;
        tick();
        sw_start = 1'b0;
    endtask

    task automatic prep();
        disarm  = 1'b1;
        irq_ack = 1'b1;
        tick();
        disarm  = 1'b0;
        irq_ack = 1'b0;
        for (int i = 0; i < 20 && running; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (timer_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", timer_start); end
        checks++; if (match_status !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", match_status); end
        checks++; if (expire_status !== 1'b0) begin errors++; $display("FAIL reset_expire got %b want 0", expire_status); end
        checks++; if (expire_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", expire_count); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (expire_count2 !== 2'd0) begin errors++; $display("FAIL reset_count2 got %0d want 0", expire_count2); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_match();
        int i;
        prep();
        compare_value = 32'd5; compare_en = 1'b1; match_irq_en = 1'b1; timer_init = 32'd10;
        pulse_arm_start();
        for (i = 0; i < 40 && !(running && curr_timer == 32'd5); i++) tick();
        checks++; if (!(running && curr_timer == 32'd5)) begin errors++; $display("FAIL match_wait timeout got curr=%0d want 5", curr_timer); end
        checks++; if (match_status !== 1'b0) begin errors++; $display("FAIL match_early got %b want 0", match_status); end
        tick();
        checks++; if (match_status !== 1'b1) begin errors++; $display("FAIL match_set got %b want 1", match_status); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL match_irq got %b want 1", irq); end
        for (i = 0; i < 40 && !expire_status; i++) tick();
        checks++; if (match_status !== 1'b1) begin errors++; $display("FAIL match_sticky got %b want 1", match_status); end
        checks++; if (expire_count !== 16'd1) begin errors++; $display("FAIL match_count got %0d want 1", expire_count); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++; if (match_status !== 1'b0) begin errors++; $display("FAIL match_ack got %b want 0", match_status); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL match_ack_irq got %b want 0", irq); end
        compare_en = 1'b0; match_irq_en = 1'b0;
    endtask

    task automatic test_single_expiry();
        int starts = 0;
        prep();
        auto_restart = 1'b0; timer_init = 32'd3;
        pulse_arm_start();
        for (int i = 0; i < 40 && !expire_status; i++) begin
            tick();
            if (timer_start) starts++;
        end
        checks++; if (expire_status !== 1'b1) begin errors++; $display("FAIL single_expire got %b want 1", expire_status); end
        checks++; if (expire_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", expire_count); end
        repeat (6) begin
            tick();
            if (timer_start) starts++;
        end
        checks++; if (starts != 0) begin errors++; $display("FAIL single_starts got %0d want 0", starts); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL single_idle got running=%b want 0", running); end
    endtask

    task automatic test_ack_collision();
        logic prev;
        int   i;
        prep();
        auto_restart = 1'b0; timer_init = 32'd2;
        pulse_arm_start();
        prev = running;
        for (i = 0; i < 40; i++) begin
            tick();
            if (prev && !running) break;
            prev = running;
        end
        checks++; if (i >= 40) begin errors++; $display("FAIL ack_wait timeout got no expiry want falling running"); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++; if (expire_status !== 1'b1) begin errors++; $display("FAIL ack_collide got %b want 1", expire_status); end
        checks++; if (expire_count !== 16'd1) begin errors++; $display("FAIL ack_count got %0d want 1", expire_count); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++; if (expire_status !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", expire_status); end
    endtask

    task automatic test_periodic();
        int starts = 0;
        logic re_armed = 1'b0;
        prep();
        auto_restart = 1'b1; restart_limit = 16'd3; timer_init = 32'd2;
        pulse_arm_start();
        for (int i = 0; i < 200 && expire_count != 16'd3; i++) begin
            // arm while already active must be ignored
            if (expire_count == 16'd1 && !re_armed) begin arm = 1'b1; re_armed = 1'b1; end
            else arm = 1'b0;
            tick();
            if (timer_start) starts++;
        end
        arm = 1'b0;
        checks++; if (expire_count !== 16'd3) begin errors++; $display("FAIL periodic_count got %0d want 3", expire_count); end
        repeat (8) begin
            tick();
            if (timer_start) starts++;
        end
        checks++; if (starts != 2) begin errors++; $display("FAIL periodic_starts got %0d want 2", starts); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL periodic_idle got running=%b want 0", running); end
        checks++; if (expire_count !== 16'd3) begin errors++; $display("FAIL periodic_hold got %0d want 3", expire_count); end
    endtask

    task automatic test_stop();
        int starts = 0;
        prep();
        auto_restart = 1'b1; restart_limit = 16'd0; timer_init = 32'd6;
        pulse_arm_start();
        for (int i = 0; i < 40 && !(running && curr_timer == 32'd2); i++) tick();
        checks++; if (curr_timer !== 32'd2) begin errors++; $display("FAIL stop_wait got curr=%0d want 2", curr_timer); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (8) begin
            tick();
            if (timer_start) starts++;
        end
        checks++; if (expire_status !== 1'b0) begin errors++; $display("FAIL stop_expire got %b want 0", expire_status); end
        checks++; if (expire_count !== 16'd0) begin errors++; $display("FAIL stop_count got %0d want 0", expire_count); end
        checks++; if (starts != 0) begin errors++; $display("FAIL stop_starts got %0d want 0", starts); end
    endtask

    task automatic test_saturation_reset();
        int starts = 0;
        prep();
        auto_restart = 1'b1; restart_limit = 16'd0; timer_init = 32'd1; expire_irq_en = 1'b1;
        pulse_arm_start();
        for (int i = 0; i < 200 && expire_count != 16'd5; i++) tick();
        checks++; if (expire_count !== 16'd5) begin errors++; $display("FAIL sat_count16 got %0d want 5", expire_count); end
        checks++; if (expire_count2 !== 2'd3) begin errors++; $display("FAIL sat_count2 got %0d want 3", expire_count2); end
        checks++; if (timer_start !== 1'b1) begin errors++; $display("FAIL sat_restart got %b want 1", timer_start); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sat_irq got %b want 1", irq); end
        reset_n = 1'b0;
        tick();
        checks++; if ({timer_start, match_status, expire_status, irq} !== 4'b0000) begin
            errors++; $display("FAIL rst_flags got %b want 0000", {timer_start, match_status, expire_status, irq}); end
        checks++; if (expire_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", expire_count); end
        checks++; if ({timer_start2, expire_status2, irq2, expire_count2} !== 5'd0) begin
            errors++; $display("FAIL rst_dut2 got %b want 00000", {timer_start2, expire_status2, irq2, expire_count2}); end
        reset_n = 1'b1;
        repeat (6) begin
            tick();
            if (timer_start) starts++;
        end
        checks++; if (starts != 0 || running !== 1'b0) begin
            errors++; $display("FAIL rst_quiet got starts=%0d running=%b want 0 0", starts, running); end
        expire_irq_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; stop = 1'b0; arm = 1'b0; disarm = 1'b0; compare_en = 1'b0;
        match_irq_en = 1'b0; expire_irq_en = 1'b0; auto_restart = 1'b0; irq_ack = 1'b0;
        sw_start = 1'b0; compare_value = 32'd0; timer_init = 32'd0; restart_limit = 16'd0;
        test_reset();
        test_match();
        test_single_expiry();
        test_ack_collision();
        test_periodic();
        test_stop();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
